aurora_parse_end: RTL and testbench

- Receive-side counterpart of the end-of-scan notification sender.
- Sits on the Aurora user RX AXI-Stream and watches for the 2-beat end packet: beat 0 header 64'h0000_0000_55aa_0001, beat 1 payload 64'h0000_0000_0000_0001 with tlast.
- On a valid end packet it emits a one-cycle eds_finish pulse to local control logic.
- Maintains received-packet and malformed-packet counters for register readback.

---
 rtl/aurora_parse_end.sv | 117 +++++++++++
 tb/tb_aurora_parse_end.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_parse_end.sv
// Aurora RX end-of-scan packet parser: flags the 2-beat end packet and keeps rx/err counters.
// Optional payload value check enabled by defining AURORA_PARSE_END_PAYLOAD_CHK_EN.
module aurora_parse_end #(
   parameter int unsigned DATA_WD   = 64,
   parameter logic [15:0] HDR_MAGIC = 16'h55aa,
   parameter logic [15:0] CMD_END   = 16'h0001
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_rst,
   input  logic [DATA_WD-1:0]     s_axis_tdata,
   input  logic [DATA_WD/8-1:0]   s_axis_tkeep,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   s_axis_tlast,
   output logic                   eds_finish,
   output logic [31:0]            eds_end_rx_cnt,
   output logic [31:0]            eds_end_err_cnt
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StPayload = 2'd1;
   localparam logic [1:0] StDrop    = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        tready_q;
   logic        finish_q;
   logic [31:0] rx_cnt_q, rx_cnt_d;
   logic [31:0] err_cnt_q, err_cnt_d;
   logic        beat;
   logic        hdr_ok;
   logic        cmd_ok;
   logic        payload_ok;
   logic        end_evt;
   logic        err_evt;

   // Upper data bits and byte enables carry no information for this parser.
   logic unused_bits;
   assign unused_bits = ^{s_axis_tkeep, s_axis_tdata[DATA_WD-1:32]};

   assign beat   = s_axis_tvalid && tready_q;
   assign hdr_ok = (s_axis_tdata[31:16] == HDR_MAGIC);
   assign cmd_ok = (s_axis_tdata[15:0] == CMD_END);

`ifdef AURORA_PARSE_END_PAYLOAD_CHK_EN
   assign payload_ok = (s_axis_tdata[31:0] == 32'h0000_0001);
`else
   assign payload_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      end_evt = 1'b0;
      err_evt = 1'b0;
      if (beat) begin
         case (state_q)
            StIdle: begin
               if (hdr_ok && cmd_ok) begin
                  if (s_axis_tlast) err_evt = 1'b1;
                  else              state_d = StPayload;
               end else if (!s_axis_tlast) begin
                  state_d = StDrop;
               end
            end
            StPayload: begin
               if (s_axis_tlast) begin
                  if (payload_ok) end_evt = 1'b1;
                  else            err_evt = 1'b1;
                  state_d = StIdle;
               end else begin
                  err_evt = 1'b1;
                  state_d = StDrop;
               end
            end
            StDrop: begin
               if (s_axis_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Counter clear wins over a coincident increment; the event is simply not counted.
   always_comb begin
      rx_cnt_d  = rx_cnt_q;
      err_cnt_d = err_cnt_q;
      if (cfg_rst) begin
         rx_cnt_d  = '0;
         err_cnt_d = '0;
      end else begin
         if (end_evt) rx_cnt_d  = rx_cnt_q + 32'd1;
         if (err_evt) err_cnt_d = err_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         tready_q  <= 1'b0;
         finish_q  <= 1'b0;
         rx_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tready_q  <= 1'b1;
         finish_q  <= end_evt;
         rx_cnt_q  <= rx_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign s_axis_tready   = tready_q;
   assign eds_finish      = finish_q;
   assign eds_end_rx_cnt  = rx_cnt_q;
   assign eds_end_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_aurora_parse_end.sv
// Self-checking bench for aurora_parse_end: directed steps plus random packets vs a packet model.
module tb_aurora_parse_end;

   localparam logic [63:0] Hdr = 64'h0000_0000_55aa_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_rst = 1'b0;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = 8'hff;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic        eds_finish;
   logic [31:0] eds_end_rx_cnt;
   logic [31:0] eds_end_err_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] exp_rx = '0;
   logic [31:0] exp_err = '0;
   logic [63:0] pkt_q[$];
   int unsigned gap_max = 0;
   logic        cfg_on_last = 1'b0;

   always #5 clk = ~clk;

   aurora_parse_end dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_rst         (cfg_rst),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .eds_finish      (eds_finish),
      .eds_end_rx_cnt  (eds_end_rx_cnt),
      .eds_end_err_cnt (eds_end_err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Packet-level outcome: 0 ignored, 1 end event, 2 malformed end packet.
   function automatic int classify();
      logic [31:0] first;
      first = pkt_q[0][31:0];
      if (first != 32'h55aa_0001) return 0;
      if (pkt_q.size() != 2) return 2;
`ifdef AURORA_PARSE_END_PAYLOAD_CHK_EN
      if (pkt_q[1][31:0] != 32'h0000_0001) return 2;
`endif
      return 1;
   endfunction

   // Drive at negedge, let a posedge pass, sample at the following negedge.
   task automatic step(input logic v, input logic [63:0] d, input logic l, input logic c,
                       input logic exp_fin);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      cfg_rst       = c;
      @(posedge clk);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      cfg_rst       = 1'b0;
      chk("finish", {31'd0, eds_finish}, {31'd0, exp_fin});
   endtask

   task automatic idle(input int unsigned n);
      for (int i = 0; i < int'(n); i++)
         step(1'b0, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b0);
   endtask

   task automatic send_pkt();
      int cls;
      int last;
      cls  = classify();
      last = pkt_q.size() - 1;
      for (int i = 0; i <= last; i++) begin
         if (gap_max != 0) idle($urandom_range(gap_max, 0));
         step(1'b1, pkt_q[i], i == last, (i == last) && cfg_on_last,
              (i == last) && (cls == 1));
      end
      if (cfg_on_last) begin
         exp_rx  = '0;
         exp_err = '0;
      end else if (cls == 1) begin
         exp_rx = exp_rx + 32'd1;
      end else if (cls == 2) begin
         exp_err = exp_err + 32'd1;
      end
      chk("rx_cnt", eds_end_rx_cnt, exp_rx);
      chk("err_cnt", eds_end_err_cnt, exp_err);
      chk("tready", {31'd0, s_axis_tready}, 32'd1);
      pkt_q.delete();
   endtask

   task automatic valid_pkt();
      pkt_q.push_back(Hdr);
      pkt_q.push_back(64'h1);
      send_pkt();
   endtask

   task automatic random_pkt();
      int unsigned kind;
      int unsigned len;
      logic [15:0] w;
      kind = $urandom_range(5, 0);
      len  = $urandom_range(3, 1);
      case (kind)
         0: begin
            pkt_q.push_back({$urandom, 32'h55aa_0001});
            pkt_q.push_back({$urandom, 32'h1});
         end
         1: pkt_q.push_back({$urandom, 32'h55aa_0001});
         2: begin
            pkt_q.push_back({$urandom, 32'h55aa_0001});
            for (int i = 0; i < int'(len) + 1; i++) pkt_q.push_back({$urandom, 32'h1});
         end
         3: begin
            w = 16'($urandom_range(16'hfffe, 2));
            pkt_q.push_back({$urandom, 16'h55aa, w});
            for (int i = 1; i < int'(len); i++) pkt_q.push_back({$urandom, $urandom});
         end
         4: begin
            w = 16'($urandom);
            if (w == 16'h55aa) w = 16'h55ab;
            pkt_q.push_back({$urandom, w, 16'($urandom)});
            for (int i = 1; i < int'(len); i++) pkt_q.push_back({$urandom, $urandom});
         end
         default: begin
            pkt_q.push_back({$urandom, 32'h55aa_0001});
            pkt_q.push_back({$urandom, $urandom});
         end
      endcase
      send_pkt();
   endtask

   initial begin
      // Reset state, with a beat offered while in reset.
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = Hdr;
      repeat (2) @(negedge clk);
      chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
      chk("rst_finish", {31'd0, eds_finish}, 32'd0);
      chk("rst_rx", eds_end_rx_cnt, 32'd0);
      chk("rst_err", eds_end_err_cnt, 32'd0);
      s_axis_tvalid = 1'b0;
      rst = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("tready_after_rst", {31'd0, s_axis_tready}, 32'd1);

      valid_pkt();
      for (int i = 0; i < 3; i++) valid_pkt();

      pkt_q.push_back(Hdr);
      send_pkt();
      pkt_q.push_back(Hdr);
      pkt_q.push_back(64'h1);
      pkt_q.push_back(64'h1);
      send_pkt();

      pkt_q.push_back(64'h55aa_0002);
      pkt_q.push_back(64'h1);
      pkt_q.push_back(64'h1);
      send_pkt();
      pkt_q.push_back(64'h1234);
      send_pkt();
      valid_pkt();

      // Preload the rx counter just below wrap.
      force dut.rx_cnt_q = 32'hffff_ffff;
      @(posedge clk);
      @(negedge clk);
      release dut.rx_cnt_q;
      exp_rx = 32'hffff_ffff;
      valid_pkt();

      // Clear in the pulse cycle.
      valid_pkt();
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      exp_rx  = '0;
      exp_err = '0;
      chk("cfg_clear_rx", eds_end_rx_cnt, exp_rx);
      chk("cfg_clear_err", eds_end_err_cnt, exp_err);
      valid_pkt();

      // Clear coinciding with the accepting beat: pulse kept, count lost.
      cfg_on_last = 1'b1;
      valid_pkt();
      cfg_on_last = 1'b0;

      pkt_q.push_back(Hdr);
      pkt_q.push_back(64'h2);
      send_pkt();

      // Reset mid-packet: the orphan payload is dropped uncounted.
      step(1'b1, Hdr, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_rx  = '0;
      exp_err = '0;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      pkt_q.push_back(64'h1);
      send_pkt();
      valid_pkt();

      gap_max = 2;
      for (int i = 0; i < 80; i++) begin
         if (i == 40) gap_max = 0;
         random_pkt();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected bench completion");
      $fatal(1, "timeout");
   end

endmodule
